player_action_encoder: RTL and testbench
========================================

# player_action_encoder

Converts a player's six raw, asynchronous push-buttons into the one-hot 6-bit action word that the player state blocks consume. It produces exactly one action per game tick. The block synchronizes and debounces each button, arbitrates simultaneous presses by fixed priority, and enforces an attack cooldown. It sits between the board buttons and each player block; one instance is used per player, and its `action_out` drives that player's own-input and the opponent's other-player-input.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button level change.
- `TICK_CYCLES`, default 8: clk cycles per game tick; must be ≥ 2.
- `ATTACK_COOLDOWN`, default 2: number of ticks after a PUNCH/KICK during which attacks are masked; 0 disables masking.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `btn`, input, 6: raw buttons, active-high, asynchronous. Bit mapping matches the action code: [5] MOVE_RIGHT, [4] MOVE_LEFT, [3] WAIT, [2] JUMP, [1] KICK, [0] PUNCH.
- `enable`, input, 1: game running; when low, the encoder idles.
- `action_out`, output, 6: registered action word, either one-hot or 6'b000000 (NONE); held for a full tick.
- `tick`, output, 1: one-cycle pulse, asserted in the first cycle a new `action_out` value is valid.

## Operation
- **Synchronizer:** two-flop synchronizer per `btn` bit; flops reset to 0.
- **Debounce:** one counter per bit.
  - When the synchronized bit differs from the debounced bit, the counter increments; otherwise it clears.
  - On reaching `DEBOUNCE_CYCLES`, the debounced bit takes the synchronized value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles is never accepted.
- **Tick counter:**
  - Counts 0 to `TICK_CYCLES-1` and wraps.
  - The capture boundary is count = `TICK_CYCLES-1`.
  - Width is $clog2(`TICK_CYCLES`).
- **Arbitration at each capture boundary:** priority JUMP > PUNCH > KICK > MOVE_LEFT > MOVE_RIGHT > WAIT > NONE.
  - MOVE_LEFT and MOVE_RIGHT debounced together cancel each other; both are ignored and arbitration falls through to WAIT/NONE.
  - While the cooldown count is non-zero, PUNCH and KICK are masked and arbitration falls through to the next eligible action.
- **Cooldown counter:**
  - Loaded with `ATTACK_COOLDOWN` when PUNCH or KICK is issued.
  - Otherwise decrements by 1 at each capture boundary, saturating at 0.
  - Width is $clog2(`ATTACK_COOLDOWN`+1), minimum 1.
- **Button behaviour:** buttons are level-sensitive. A held button reissues its action every tick, subject to cooldown.
- **`enable` low:**
  - Tick counter, cooldown counter and `action_out` are forced to 0; `tick` stays 0.
  - The synchronizer and debouncer keep running.
  - When `enable` rises, the first capture happens `TICK_CYCLES` cycles later.

## Timing
- **Reset values:** `action_out` = 6'b000000, `tick` = 0, tick counter = 0, cooldown = 0, all debounced bits = 0.
- **`rst_n` asserted mid-tick:** all state clears immediately; no partial action is emitted.
- **`tick` period:** with `enable` high, `tick` pulses every `TICK_CYCLES` cycles. The first pulse occurs `TICK_CYCLES` rising edges after `rst_n` deasserts.
- **Button-to-debounced latency:** 2 (sync) + `DEBOUNCE_CYCLES` cycles from a clean edge on `btn`.
- **Button-to-action latency:** the debounced value is captured at the next boundary. Worst-case button-to-`action_out` latency is 2 + `DEBOUNCE_CYCLES` + `TICK_CYCLES` cycles.
- **Capture edge:** `action_out` and `tick` update on the same edge.
- **Hold:** `action_out` is stable between ticks.
- **Boundary coincidence:** a debounce completing on the same edge as a capture boundary is not seen until the next tick, because capture uses the pre-edge debounced value.

## Structure
- **Shared package `game_pkg`:**
  - Action constants ACT_MOVE_RIGHT, ACT_MOVE_LEFT, ACT_WAIT, ACT_JUMP, ACT_KICK, ACT_PUNCH, ACT_NONE (6 bits).
  - Bit-index constants for the `btn` mapping.
  - These constants are shared with the player blocks.
- **Sub-module `button_debouncer`:** single bit, parameterized by `DEBOUNCE_CYCLES`, containing the synchronizer and the debounce counter. It is instantiated six times.
- **Top level:** tick counter, arbiter, cooldown counter and output registers.

## Test plan
All scenarios use default parameters unless noted.
- **Reset and idle:** `btn` = 0, release `rst_n` → `action_out` = 0 throughout; `tick` pulses at cycles 8, 16, 24.
- **Single press:** `btn[0]` held from cycle 1 → debounced by cycle 7; `action_out` = 6'b000001 at the next boundary.
  - With `ATTACK_COOLDOWN` = 2 → PUNCH issues once, then NONE for 2 ticks, then PUNCH again.
- **Priority:** `btn` = 6'b000111 held → `action_out` = JUMP every tick. `btn` = 6'b110000 → NONE. `btn` = 6'b111000 → WAIT.
- **Cooldown fallthrough:** `btn` = 6'b100011 held → sequence PUNCH, MOVE_RIGHT, MOVE_RIGHT, PUNCH.
- **Debounce reject:** 3-cycle pulse on `btn[2]` → `action_out` never shows JUMP. A 10-cycle pulse → JUMP appears for exactly one tick.
- **Enable and mid-tick reset:**
  - `enable` dropped mid-tick → `action_out` = 0 next cycle and no `tick`.
  - `enable` re-raised → `tick` 8 cycles later.
  - `rst_n` pulsed low mid-tick → immediate clear of outputs and counters.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: action codes and the button bit mapping used by
// the action encoder and the player state blocks.
package game_pkg;

    localparam int ACTION_W = 6;

    typedef logic [ACTION_W-1:0] action_t;

    localparam int BTN_PUNCH      = 0;
    localparam int BTN_KICK       = 1;
    localparam int BTN_JUMP       = 2;
    localparam int BTN_WAIT       = 3;
    localparam int BTN_MOVE_LEFT  = 4;
    localparam int BTN_MOVE_RIGHT = 5;

    localparam action_t ACT_NONE       = 6'b000000;
    localparam action_t ACT_PUNCH      = 6'b000001;
    localparam action_t ACT_KICK       = 6'b000010;
    localparam action_t ACT_JUMP       = 6'b000100;
    localparam action_t ACT_WAIT       = 6'b001000;
    localparam action_t ACT_MOVE_LEFT  = 6'b010000;
    localparam action_t ACT_MOVE_RIGHT = 6'b100000;

    function automatic logic is_attack(input action_t act);
        return (act == ACT_PUNCH) || (act == ACT_KICK);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-bit two-flop synchronizer followed by a stable-run debounce counter.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta_r;
    logic          sync_r;
    logic          db_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          db_nxt_s;

    // Accept the synchronized level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        cnt_nxt_s = '0;
        db_nxt_s  = db_r;
        if (sync_r != db_r) begin
            if (cnt_r == CNT_LAST) begin
                db_nxt_s  = sync_r;
                cnt_nxt_s = '0;
            end else begin
                cnt_nxt_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Synchronizer and debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
            db_r        <= 1'b0;
            cnt_r       <= '0;
        end else begin
            sync_meta_r <= btn_raw;
            sync_r      <= sync_meta_r;
            db_r        <= db_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

    assign btn_db = db_r;

endmodule

// File: rtl/player_action_encoder.sv
// Debounces six player buttons and issues one prioritized, cooldown-limited
// one-hot action per game tick.
module player_action_encoder
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_CYCLES     = 8,
    parameter int ATTACK_COOLDOWN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn,
    input  logic       enable,
    output logic [5:0] action_out,
    output logic       tick
);

    localparam int TW  = $clog2(TICK_CYCLES);
    localparam int CDW = (ATTACK_COOLDOWN > 0) ? $clog2(ATTACK_COOLDOWN + 1) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [CDW-1:0] CD_LOAD   = CDW'(ATTACK_COOLDOWN);

    logic [5:0]     db_s;
    logic [TW-1:0]  phase_r;
    logic [TW-1:0]  phase_nxt_s;
    logic [CDW-1:0] cd_r;
    logic [CDW-1:0] cd_nxt_s;
    action_t        act_r;
    action_t        act_nxt_s;
    action_t        arb_s;
    logic           tick_r;
    logic           tick_nxt_s;
    logic           attack_ok_s;
    logic           left_only_s;
    logic           right_only_s;

    for (genvar i = 0; i < 6; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn[i]),
            .btn_db (db_s[i])
        );
    end

    assign attack_ok_s  = (cd_r == '0);
    assign left_only_s  = db_s[BTN_MOVE_LEFT]  && !db_s[BTN_MOVE_RIGHT];
    assign right_only_s = db_s[BTN_MOVE_RIGHT] && !db_s[BTN_MOVE_LEFT];

    // Fixed-priority arbiter; opposing moves cancel, attacks masked during cooldown.
    always_comb begin
        arb_s = ACT_NONE;
        if (db_s[BTN_JUMP]) begin
            arb_s = ACT_JUMP;
        end else if (db_s[BTN_PUNCH] && attack_ok_s) begin
            arb_s = ACT_PUNCH;
        end else if (db_s[BTN_KICK] && attack_ok_s) begin
            arb_s = ACT_KICK;
        end else if (left_only_s) begin
            arb_s = ACT_MOVE_LEFT;
        end else if (right_only_s) begin
            arb_s = ACT_MOVE_RIGHT;
        end else if (db_s[BTN_WAIT]) begin
            arb_s = ACT_WAIT;
        end else begin
            arb_s = ACT_NONE;
        end
    end

    // Tick phase, cooldown and output next-state; capture uses pre-edge debounced levels.
    always_comb begin
        phase_nxt_s = phase_r;
        cd_nxt_s    = cd_r;
        act_nxt_s   = act_r;
        tick_nxt_s  = 1'b0;
        if (!enable) begin
            phase_nxt_s = '0;
            cd_nxt_s    = '0;
            act_nxt_s   = ACT_NONE;
        end else if (phase_r == TICK_LAST) begin
            phase_nxt_s = '0;
            tick_nxt_s  = 1'b1;
            act_nxt_s   = arb_s;
            if (is_attack(arb_s)) begin
                cd_nxt_s = CD_LOAD;
            end else if (cd_r != '0) begin
                cd_nxt_s = cd_r - CDW'(1);
            end else begin
                cd_nxt_s = '0;
            end
        end else begin
            phase_nxt_s = phase_r + TW'(1);
        end
    end

    // Tick counter, cooldown counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= '0;
            cd_r    <= '0;
            act_r   <= ACT_NONE;
            tick_r  <= 1'b0;
        end else begin
            phase_r <= phase_nxt_s;
            cd_r    <= cd_nxt_s;
            act_r   <= act_nxt_s;
            tick_r  <= tick_nxt_s;
        end
    end

    assign action_out = act_r;
    assign tick       = tick_r;

endmodule

// File: tb/tb_player_action_encoder.sv
// Randomized self-checking bench for player_action_encoder against a
// cycle-level behavioural model of the button-to-action rules.
module tb_player_action_encoder;

    localparam int DB = 4;
    localparam int TC = 8;
    localparam int AC = 2;

    logic       clk;
    logic       rst_n;
    logic [5:0] btn;
    logic       enable;
    logic [5:0] action_out;
    logic       tick;

    int n_checks;
    int n_fail;

    // Model state
    logic [5:0] m_s1, m_s2, m_db;
    int         m_run[6];
    int         m_phase;
    int         m_cd;
    logic [5:0] m_act;
    logic       m_tick;

    player_action_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_CYCLES    (TC),
        .ATTACK_COOLDOWN(AC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .enable    (enable),
        .action_out(action_out),
        .tick      (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 6'b0; m_s2 = 6'b0; m_db = 6'b0;
        for (int i = 0; i < 6; i++) m_run[i] = 0;
        m_phase = 0; m_cd = 0; m_act = 6'b0; m_tick = 1'b0;
    endtask

    // Walk the priority list JUMP, PUNCH, KICK, LEFT, RIGHT, WAIT; first eligible wins.
    function automatic logic [5:0] m_arbitrate(input logic [5:0] d, input int cd);
        int         order[6] = '{2, 0, 1, 4, 5, 3};
        logic [5:0] one = 6'b000001;
        for (int k = 0; k < 6; k++) begin
            int idx = order[k];
            bit ok = 1'b1;
            if ((idx == 0 || idx == 1) && cd != 0) ok = 1'b0;
            if (idx == 4 && d[5]) ok = 1'b0;
            if (idx == 5 && d[4]) ok = 1'b0;
            if (d[idx] && ok) return one << idx;
        end
        return 6'b000000;
    endfunction

    task automatic model_edge();
        logic [5:0] db_pre = m_db;
        for (int i = 0; i < 6; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] >= DB) begin
                    m_db[i]  = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
        if (!enable) begin
            m_phase = 0; m_cd = 0; m_act = 6'b0; m_tick = 1'b0;
        end else if (m_phase == TC - 1) begin
            m_phase = 0;
            m_tick  = 1'b1;
            m_act   = m_arbitrate(db_pre, m_cd);
            if (m_act == 6'b000001 || m_act == 6'b000010) m_cd = AC;
            else if (m_cd > 0) m_cd = m_cd - 1;
        end else begin
            m_phase = m_phase + 1;
            m_tick  = 1'b0;
        end
    endtask

    task automatic step(input logic [5:0] b, input logic e);
        btn    = b;
        enable = e;
        model_edge();
        @(posedge clk);
        #1;
        check_eq("action_out", {26'b0, action_out}, {26'b0, m_act});
        check_eq("tick", {31'b0, tick}, {31'b0, m_tick});
    endtask

    task automatic hold(input logic [5:0] b, input logic e, input int n);
        for (int c = 0; c < n; c++) step(b, e);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_action", {26'b0, action_out}, 32'd0);
        check_eq("rst_tick", {31'b0, tick}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_hold_action", {26'b0, action_out}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        btn      = 6'b0;
        enable   = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_action", {26'b0, action_out}, 32'd0);
        check_eq("reset_tick", {31'b0, tick}, 32'd0);
        rst_n = 1'b1;

        // Directed scenarios
        hold(6'b000000, 1'b1, 30);
        hold(6'b000001, 1'b1, 60);
        hold(6'b000111, 1'b1, 30);
        hold(6'b110000, 1'b1, 30);
        hold(6'b111000, 1'b1, 30);
        hold(6'b100011, 1'b1, 60);
        hold(6'b000000, 1'b1, 20);
        hold(6'b000100, 1'b1, 3);
        hold(6'b000000, 1'b1, 30);
        hold(6'b000100, 1'b1, 10);
        hold(6'b000000, 1'b1, 30);
        hold(6'b010000, 1'b1, 13);
        hold(6'b010000, 1'b0, 5);
        hold(6'b010000, 1'b1, 20);
        hold(6'b000010, 1'b1, 11);
        pulse_reset();
        hold(6'b000010, 1'b1, 30);

        // Randomized segments
        for (int seg = 0; seg < 400; seg++) begin
            logic [5:0] pat;
            int         len;
            int         sel;
            logic       en;
            sel = $urandom_range(0, 99);
            pat = 6'($urandom) & 6'($urandom);
            len = (sel < 25) ? $urandom_range(1, 5) : $urandom_range(6, 40);
            en  = (sel < 92) ? 1'b1 : 1'b0;
            if (sel >= 97) begin
                hold(pat, 1'b1, $urandom_range(1, 7));
                pulse_reset();
            end
            hold(pat, en, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
